// File: rtl/hps_reset_pkg.sv
// rtl/hps_reset_pkg.sv - shared types, indices and priority helper for the HPS reset sequencer
//
// Purpose : common definitions used by hps_reset_sequencer and its testbench.
//   tEHpsRstState : sequencer FSM states (IDLE, ASSERT, HOLDOFF)
//   COLD/WARM/DBG : bit positions within every 3-bit reset vector
//   tHpsRstVec    : one bit per reset type, in COLD/WARM/DBG order
//   pick_highest  : one-hot of the highest-priority set bit (cold > warm > debug)

package hps_reset_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        HOLDOFF = 2'd2
    } tEHpsRstState;

    localparam int COLD = 0;
    localparam int WARM = 1;
    localparam int DBG  = 2;

    typedef logic [2:0] tHpsRstVec;

    function automatic tHpsRstVec pick_highest(input tHpsRstVec v);
        tHpsRstVec r;
        r = '0;
        if (v[COLD]) begin
            r[COLD] = 1'b1;
        end else if (v[WARM]) begin
            r[WARM] = 1'b1;
        end else if (v[DBG]) begin
            r[DBG] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - multi-flop synchroniser with rising-edge pulse output
//
// Purpose : brings an asynchronous bus into the clock domain and produces a
//           one-clock pulse per bit on each rising edge of the synchronised level.
// Ports   :
//   i_clk   in  1      clock
//   i_rst   in  1      synchronous reset, active-high
//   i_data  in  WIDTH  asynchronous level inputs
//   o_rise  out WIDTH  one-clock pulse per synchronised rising edge
// Parameters:
//   WIDTH        bus width
//   STAGES       synchroniser depth (>=2)
//   RESET_VALUE  reset value of the sync flops and the edge-history register

module sync_edge_detect #(
    parameter int               WIDTH       = 3,
    parameter int               STAGES      = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_rise
);

    logic [WIDTH-1:0] r_sync [STAGES];
    logic [WIDTH-1:0] r_prev;

    // History resets to RESET_VALUE (all ones for the sequencer) so a level
    // already high at reset release is not mistaken for a fresh edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int s = 0; s < STAGES; s++) begin
                r_sync[s] <= RESET_VALUE;
            end
            r_prev <= RESET_VALUE;
        end else begin
            r_sync[0] <= i_data;
            for (int s = 1; s < STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_rise = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/hps_reset_sequencer.sv
// rtl/hps_reset_sequencer.sv - turns source-vector rising edges into serialised HPS reset pulses
//
// Purpose : each rising edge on piul3Source latches a request; requests are
//           serviced one at a time (cold > warm > debug) as a PULSE_CYCLES-long
//           active-low pulse followed by a HOLDOFF_CYCLES quiet window.
// Ports   :
//   piul1Clock     in  1  clock for all logic
//   piul1Reset     in  1  synchronous reset, active-high
//   piul3Source    in  3  bit0 cold, bit1 warm, bit2 debug reset command
//   poul1ColdRstN  out 1  HPS cold reset request, active-low
//   poul1WarmRstN  out 1  HPS warm reset request, active-low
//   poul1DbgRstN   out 1  HPS debug reset request, active-low
//   poul1Busy      out 1  sequencer not idle or a request is pending
//   poul3Pending   out 3  latched requests not yet serviced

module hps_reset_sequencer
    import hps_reset_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int PULSE_CYCLES   = 16,
    parameter int HOLDOFF_CYCLES = 256
) (
    input  logic       piul1Clock,
    input  logic       piul1Reset,
    input  logic [2:0] piul3Source,
    output logic       poul1ColdRstN,
    output logic       poul1WarmRstN,
    output logic       poul1DbgRstN,
    output logic       poul1Busy,
    output logic [2:0] poul3Pending
);

    localparam int CNT_MAX = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LOAD  = CW'((HOLDOFF_CYCLES > 0) ? (HOLDOFF_CYCLES - 1) : 0);

    tEHpsRstState r_state;
    tEHpsRstState w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    tHpsRstVec     r_pending;
    tHpsRstVec     w_pending_nxt;
    tHpsRstVec     r_sel;
    tHpsRstVec     w_sel_nxt;
    tHpsRstVec     w_clear;
    tHpsRstVec     w_pick;
    tHpsRstVec     w_rise;
    tHpsRstVec     r_rst_n;
    tHpsRstVec     w_rst_n_nxt;
    logic          r_busy;
    logic          w_busy_nxt;

    sync_edge_detect #(
        .WIDTH       (3),
        .STAGES      (SYNC_STAGES),
        .RESET_VALUE (3'b111)
    ) u_sync_edge (
        .i_clk  (piul1Clock),
        .i_rst  (piul1Reset),
        .i_data (piul3Source),
        .o_rise (w_rise)
    );

    assign w_pick = pick_highest(r_pending);

    // State register: FSM, shared counter, pending, selection and the
    // registered outputs all advance together.
    always_ff @(posedge piul1Clock) begin
        if (piul1Reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_pending <= '0;
            r_sel     <= '0;
            r_rst_n   <= '1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pending <= w_pending_nxt;
            r_sel     <= w_sel_nxt;
            r_rst_n   <= w_rst_n_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    // Next-state logic. The counter is loaded with N-1 on entry so each
    // state lasts exactly N clocks.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_sel;
        w_clear     = '0;
        case (r_state)
            IDLE: begin
                if (|r_pending) begin
                    w_sel_nxt   = w_pick;
                    w_clear     = w_pick;
                    w_cnt_nxt   = PULSE_LOAD;
                    w_state_nxt = ASSERT;
                end
            end
            ASSERT: begin
                if (r_cnt == '0) begin
                    if (HOLDOFF_CYCLES == 0) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt   = HOLD_LOAD;
                        w_state_nxt = HOLDOFF;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            HOLDOFF: begin
                if (r_cnt == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        // Clear before set: an edge landing on the same clock its type is
        // taken for service stays pending and earns one more pulse.
        w_pending_nxt = (r_pending & ~w_clear) | w_rise;
    end

    // Output logic, computed from the next state so the registered outputs
    // line up with the state they belong to.
    always_comb begin
        w_rst_n_nxt = '1;
        if (w_state_nxt == ASSERT) begin
            w_rst_n_nxt = ~w_sel_nxt;
        end
        w_busy_nxt = (w_state_nxt != IDLE) | (|w_pending_nxt);
    end

    assign poul1ColdRstN = r_rst_n[COLD];
    assign poul1WarmRstN = r_rst_n[WARM];
    assign poul1DbgRstN  = r_rst_n[DBG];
    assign poul1Busy     = r_busy;
    assign poul3Pending  = r_pending;

endmodule

// File: tb/tb_hps_reset_sequencer.sv
// tb/tb_hps_reset_sequencer.sv - self-checking bench for hps_reset_sequencer

module tb_hps_reset_sequencer;

    localparam int STG = 2;
    localparam int P   = 4;
    localparam int H   = 8;

    logic       clk;
    logic       rst;
    logic [2:0] src;
    logic [2:0] src2;
    logic       cold1, warm1, dbg1, busy1;
    logic [2:0] pend1;
    logic       cold2, warm2, dbg2, busy2;
    logic [2:0] pend2;

    int n_checks = 0;
    int n_err    = 0;

    hps_reset_sequencer #(.SYNC_STAGES(STG), .PULSE_CYCLES(P), .HOLDOFF_CYCLES(H)) dut (
        .piul1Clock    (clk),
        .piul1Reset    (rst),
        .piul3Source   (src),
        .poul1ColdRstN (cold1),
        .poul1WarmRstN (warm1),
        .poul1DbgRstN  (dbg1),
        .poul1Busy     (busy1),
        .poul3Pending  (pend1)
    );

    hps_reset_sequencer #(.SYNC_STAGES(STG), .PULSE_CYCLES(P), .HOLDOFF_CYCLES(0)) dut_h0 (
        .piul1Clock    (clk),
        .piul1Reset    (rst),
        .piul3Source   (src2),
        .poul1ColdRstN (cold2),
        .poul1WarmRstN (warm2),
        .poul1DbgRstN  (dbg2),
        .poul1Busy     (busy2),
        .poul3Pending  (pend2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rn [2];
    assign rn[0] = {dbg1, warm1, cold1};
    assign rn[1] = {dbg2, warm2, cold2};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Timestamp model: a request seen at clock c starts a pulse that is low
    // for clocks c..c+P-1, and the engine may next pick at c+P+H+1.
    int         cyc = 0;
    int         free_at = 0;
    int         p_type = -1;
    int         p_last = -1;
    bit         model_ok = 0;
    logic [2:0] m_pend;
    logic [2:0] hist [STG+2];
    logic [2:0] rise;
    logic [2:0] e_rstn;
    logic       e_busy;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            for (int k = 0; k < STG + 2; k++) hist[k] = 3'b111;
            m_pend   = 3'b000;
            free_at  = cyc + 1;
            p_type   = -1;
            p_last   = -1;
            model_ok = 1;
        end else begin
            for (int k = STG + 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = src;
            rise = hist[STG] & ~hist[STG+1];
            if (cyc >= free_at && m_pend != 3'b000) begin
                p_type = m_pend[0] ? 0 : (m_pend[1] ? 1 : 2);
                m_pend[p_type] = 1'b0;
                p_last  = cyc + P - 1;
                free_at = cyc + P + H + 1;
            end
            m_pend = m_pend | rise;
        end
        e_rstn = 3'b111;
        if (p_type >= 0 && cyc <= p_last) e_rstn[p_type] = 1'b0;
        e_busy = (cyc < free_at - 1) || (m_pend != 3'b000);
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("cycle_outputs", {25'd0, rn[0], busy1, pend1}, {25'd0, e_rstn, e_busy, m_pend});
        end
    end

    // Pulse monitor for hand-computed expectations: count, start and width per type.
    int mon_cnt   [2][3];
    int mon_start [2][3];
    int mon_width [2][3];
    int mon_run   [2][3];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 3; k++) begin
                if (rn[i][k] === 1'b0) begin
                    if (mon_run[i][k] == 0) begin
                        mon_cnt[i][k]++;
                        mon_start[i][k] = cyc;
                    end
                    mon_run[i][k]++;
                    mon_width[i][k] = mon_run[i][k];
                end else begin
                    mon_run[i][k] = 0;
                end
            end
        end
    end

    task automatic clear_mon();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 3; k++) begin
                mon_cnt[i][k]   = 0;
                mon_start[i][k] = 0;
                mon_width[i][k] = 0;
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_low(input int inst, input int k, input int budget, input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rn[inst][k] === 1'b0) begin
                ok = 1;
                break;
            end
        end
        chk(name, {31'd0, ok}, 32'd1);
    endtask

    int t0;

    initial begin
        for (int i = 0; i < 2; i++) for (int k = 0; k < 3; k++) mon_run[i][k] = 0;
        clear_mon();
        rst = 1'b1; src = 3'b000; src2 = 3'b000;
        tick(3);
        chk("reset_outputs", {27'd0, cold1, warm1, dbg1, busy1, |pend1}, {27'd0, 5'b11100});
        rst = 1'b0;
        tick(3);

        // 1: single cold edge
        clear_mon(); src = 3'b001; t0 = cyc;
        tick(30);
        chk("t1_cold_delay", mon_start[0][0] - t0, 4);
        chk("t1_cold_width", mon_width[0][0], 4);
        chk("t1_cold_count", mon_cnt[0][0], 1);
        chk("t1_other_count", mon_cnt[0][1] + mon_cnt[0][2], 0);
        chk("t1_busy_end", {31'd0, busy1}, 0);
        src = 3'b000; tick(5);

        // 2: all three at once
        clear_mon(); src = 3'b111;
        tick(60);
        chk("t2_counts", mon_cnt[0][0] * 100 + mon_cnt[0][1] * 10 + mon_cnt[0][2], 111);
        chk("t2_warm_after_cold", mon_start[0][1] - mon_start[0][0], 13);
        chk("t2_dbg_after_warm", mon_start[0][2] - mon_start[0][1], 13);
        chk("t2_widths", mon_width[0][0] + mon_width[0][1] + mon_width[0][2], 12);
        src = 3'b000; tick(5);

        // 3: cold arrives during warm pulse
        clear_mon(); src = 3'b010;
        wait_low(0, 1, 20, "t3_warm_start");
        src = 3'b011;
        tick(45);
        chk("t3_warm_width", mon_width[0][1], 4);
        chk("t3_cold_after_warm", mon_start[0][0] - mon_start[0][1], 13);
        chk("t3_cold_count", mon_cnt[0][0], 1);

        // 4: warm held high across reset release
        clear_mon(); rst = 1'b1; src = 3'b010;
        tick(2); rst = 1'b0;
        tick(20);
        chk("t4_no_pulse", mon_cnt[0][0] + mon_cnt[0][1] + mon_cnt[0][2], 0);
        src = 3'b000; tick(4); src = 3'b010;
        tick(30);
        chk("t4_one_warm", mon_cnt[0][1], 1);

        // 5: debug toggled twice during a cold pulse
        src = 3'b000; tick(4);
        clear_mon(); src = 3'b001;
        wait_low(0, 0, 20, "t5_cold_start");
        src = 3'b101; tick(2); src = 3'b001; tick(2);
        src = 3'b101; tick(2); src = 3'b001;
        tick(40);
        chk("t5_dbg_count", mon_cnt[0][2], 1);
        chk("t5_dbg_after_cold", mon_start[0][2] - mon_start[0][0], 13);

        // 6: reset on second low clock of cold pulse, warm pending
        src = 3'b000; tick(4);
        clear_mon(); src = 3'b011;
        wait_low(0, 0, 20, "t6_cold_start");
        tick(1); rst = 1'b1;
        tick(1);
        chk("t6_after_reset", {29'd0, cold1, busy1, |pend1}, {29'd0, 3'b100});
        rst = 1'b0;
        tick(30);
        chk("t6_counts", mon_cnt[0][0] * 10 + mon_cnt[0][1], 10);

        // 7: zero-holdoff instance, back-to-back pulses
        clear_mon(); src2 = 3'b111; t0 = cyc;
        tick(40);
        chk("t7_cold_delay", mon_start[1][0] - t0, 4);
        chk("t7_warm_after_cold", mon_start[1][1] - mon_start[1][0], 5);
        chk("t7_dbg_after_warm", mon_start[1][2] - mon_start[1][1], 5);
        chk("t7_widths", mon_width[1][0] + mon_width[1][1] + mon_width[1][2], 12);
        chk("t7_busy_end", {31'd0, busy2}, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
